// File: rtl/frag_pkg.sv
// Shared definitions for the fragment lane arbiter and the tx lane scheduler:
// fragment geometry, header field offsets, arbiter FSM encoding.
package frag_pkg;

    localparam int AURORA_WIDTH = 256;
    localparam int NUMBER_FRAG  = 5;

    // Header field offsets within a fragment.
    localparam int SRC_LSB      = 0;
    localparam int SRC_W        = 2;
    localparam int DST_LSB      = 2;
    localparam int DST_W        = 2;
    localparam int FNUM_LSB     = 4;
    localparam int FNUM_W       = 3;
    localparam int PAYLOAD_LSB  = 9;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        OFFER   = 2'd3
    } arb_state_t;

    // A fragment is kept only if it is addressed to us and its sequence
    // number is inside the packet.
    function automatic logic hdr_ok(input logic [DST_W-1:0]  dst,
                                    input logic [FNUM_W-1:0] fnum,
                                    input logic [DST_W-1:0]  my_id,
                                    input int                num_frag);
        return (dst == my_id) && (int'(fnum) < num_frag);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr,
// wrapping, so the last winner gets lowest priority next time.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] cand;

    // Scan ptr+1 .. ptr+N and take the first asserted request.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/frag_lane_arbiter.sv
// Shares one fragment reassembly engine between several lane receive FIFOs.
// One fragment at a time: pick a lane, pop it, check the header, then either
// offer it downstream or drop it and count the drop.
module frag_lane_arbiter
    import frag_pkg::*;
#(
    parameter int AURORA_WIDTH  = frag_pkg::AURORA_WIDTH,
    parameter int NUM_LANES     = 4,
    parameter int LANE_ID_WIDTH = 2,
    parameter int MY_ROUTER_ID  = 0,
    parameter int NUMBER_FRAG   = frag_pkg::NUMBER_FRAG,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_LANES-1:0]              empty_lane_fifo,
    output logic [NUM_LANES-1:0]              rd_lane_fifo,
    input  logic [NUM_LANES*AURORA_WIDTH-1:0] frag_lane,
    input  logic [NUM_LANES-1:0]              lane_enable,
    output logic                              frag_valid,
    input  logic                              frag_ready,
    output logic [AURORA_WIDTH-1:0]           frag_out,
    output logic [LANE_ID_WIDTH-1:0]          frag_lane_id,
    output logic [CNT_WIDTH-1:0]              drop_cnt,
    output logic                              busy
);

    arb_state_t                 state, state_nx;
    logic [NUM_LANES-1:0]       req;
    logic [NUM_LANES-1:0]       pick_gnt;
    logic [LANE_ID_WIDTH-1:0]   pick_idx;
    logic                       pick_any;
    logic [NUM_LANES-1:0]       grant_oh;
    logic [LANE_ID_WIDTH-1:0]   grant_idx;
    logic [LANE_ID_WIDTH-1:0]   rr_ptr;
    logic [AURORA_WIDTH-1:0]    lane_data [NUM_LANES];
    logic [AURORA_WIDTH-1:0]    cap_data;
    logic                       hdr_pass;

    // Empty is trusted at this sample; a lane going empty/disabled later
    // does not cancel the pop already committed to.
    assign req = ~empty_lane_fifo & lane_enable;

    rr_arbiter #(
        .N (NUM_LANES),
        .W (LANE_ID_WIDTH)
    ) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_data[g] = frag_lane[g*AURORA_WIDTH +: AURORA_WIDTH];
    end

    // FIFO read data arrives the cycle after the strobe, i.e. in CAPTURE.
    assign cap_data = lane_data[grant_idx];
    assign hdr_pass = hdr_ok(cap_data[DST_LSB +: DST_W],
                             cap_data[FNUM_LSB +: FNUM_W],
                             DST_W'(MY_ROUTER_ID), NUMBER_FRAG);

    assign rd_lane_fifo = (state == POP) ? grant_oh : '0;
    assign frag_valid   = (state == OFFER);
    assign busy         = (state != ARB);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ARB;
        else     state <= state_nx;
    end

    // Next-state: grant, pop, check, offer; drops go straight back to ARB.
    always_comb begin
        state_nx = state;
        unique case (state)
            ARB:     if (pick_any)   state_nx = POP;
            POP:                     state_nx = CAPTURE;
            CAPTURE: state_nx = hdr_pass ? OFFER : ARB;
            OFFER:   if (frag_ready) state_nx = ARB;
            default:                 state_nx = ARB;
        endcase
    end

    // Grant/pointer capture, fragment capture and saturating drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_oh     <= '0;
            grant_idx    <= '0;
            rr_ptr       <= LANE_ID_WIDTH'(NUM_LANES - 1);
            frag_out     <= '0;
            frag_lane_id <= '0;
            drop_cnt     <= '0;
        end else begin
            if (state == ARB && pick_any) begin
                grant_oh  <= pick_gnt;
                grant_idx <= pick_idx;
                rr_ptr    <= pick_idx;
            end
            if (state == CAPTURE) begin
                if (hdr_pass) begin
                    frag_out     <= cap_data;
                    frag_lane_id <= grant_idx;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frag_lane_arbiter.sv
// Bench for frag_lane_arbiter: lane FIFO models with 1-cycle read latency,
// scoreboard of expected fragments in expected grant order, table of
// single-fragment header cases, and sequences for fairness, drops,
// backpressure, masking, reset and counter saturation.
module tb_frag_lane_arbiter;

    localparam int NL = 4;
    localparam int AW = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic [NL-1:0]       empty_lane_fifo;
    logic [NL-1:0]       rd_lane_fifo;
    logic [NL-1:0][AW-1:0] lane_dat;
    logic [NL*AW-1:0]    frag_lane;
    logic [NL-1:0]       lane_enable;
    logic                frag_valid;
    logic                frag_ready;
    logic [AW-1:0]       frag_out;
    logic [1:0]          frag_lane_id;
    logic [15:0]         drop_cnt;
    logic                busy;

    // Small-counter instance used only for saturation.
    logic                sat_rst;
    logic [NL-1:0]       sat_rd;
    logic [NL*AW-1:0]    sat_lane;
    logic                sat_valid;
    logic [AW-1:0]       sat_out;
    logic [1:0]          sat_id;
    logic [2:0]          sat_drop;
    logic                sat_busy;

    assign frag_lane = lane_dat;

    always #5 clk = ~clk;

    frag_lane_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .empty_lane_fifo (empty_lane_fifo),
        .rd_lane_fifo    (rd_lane_fifo),
        .frag_lane       (frag_lane),
        .lane_enable     (lane_enable),
        .frag_valid      (frag_valid),
        .frag_ready      (frag_ready),
        .frag_out        (frag_out),
        .frag_lane_id    (frag_lane_id),
        .drop_cnt        (drop_cnt),
        .busy            (busy)
    );

    frag_lane_arbiter #(.CNT_WIDTH(3)) dut_sat (
        .clk             (clk),
        .rst             (sat_rst),
        .empty_lane_fifo (4'b1110),
        .rd_lane_fifo    (sat_rd),
        .frag_lane       (sat_lane),
        .lane_enable     (4'b1111),
        .frag_valid      (sat_valid),
        .frag_ready      (1'b1),
        .frag_out        (sat_out),
        .frag_lane_id    (sat_id),
        .drop_cnt        (sat_drop),
        .busy            (sat_busy)
    );

    typedef struct {
        logic [AW-1:0] data;
        logic [1:0]    lane;
    } exp_t;

    typedef struct {
        int         lane;
        logic [1:0] dst;
        logic [2:0] fn;
        bit         pass;
    } vec_t;

    logic [AW-1:0] lq [NL][$];
    exp_t          sb[$];
    int            glog[$];
    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;
    logic [2:0]    sat_prev = '0;
    bit            sat_wrap = 0;
    bit            sat_bad  = 0;
    bit            sat_busy_seen = 0;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NL; i++) empty_lane_fifo[i] = (lq[i].size() == 0);
    endtask

    function automatic logic [AW-1:0] mk(input logic [1:0] dst, input logic [2:0] fn);
        logic [AW-1:0] d;
        for (int k = 0; k < AW/32; k++) d[k*32 +: 32] = $urandom;
        d[3:2] = dst;
        d[6:4] = fn;
        return d;
    endfunction

    // One clock: observe at negedge, let the edge happen, then model the
    // FIFO pop (data valid from just after the strobed edge).
    task automatic step();
        logic [NL-1:0] rd_s;
        rd_s = rd_lane_fifo;
        if (frag_valid === 1'b1 && frag_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frag act lane=%0d exp none", frag_lane_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frag_out", frag_out, e.data);
                chk("frag_lane_id", AW'(frag_lane_id), AW'(e.lane));
            end
        end
        if (!sat_rst) begin
            if (sat_drop < sat_prev) sat_wrap = 1;
            sat_prev = sat_drop;
            if ((sat_rd & 4'b1110) != 0) sat_bad = 1;
            if (sat_busy) sat_busy_seen = 1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (rd_s[i] === 1'b1) begin
                glog.push_back(i);
                if (lq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_empty act lane=%0d exp no read", i);
                end else begin
                    lane_dat[i] = lq[i].pop_front();
                end
            end
        end
        refresh();
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_rd"},    AW'(rd_lane_fifo), '0);
        chk({nm, "_valid"}, AW'(frag_valid),   '0);
        chk({nm, "_busy"},  AW'(busy),         '0);
        chk({nm, "_drop"},  AW'(drop_cnt),     '0);
        chk({nm, "_out"},   frag_out,          '0);
        chk({nm, "_id"},    AW'(frag_lane_id), '0);
    endtask

    vec_t          vt[8];
    logic [AW-1:0] d, d2, hold;
    int            exp_drops;
    int            hs0;
    logic [15:0]   drops0;
    bit            stable, rdseen;
    logic [AW-1:0] a3 [2];
    logic [AW-1:0] a1 [2];

    initial begin
        vt[0] = '{2, 2'd0, 3'd1, 1'b1};
        vt[1] = '{0, 2'd0, 3'd0, 1'b1};
        vt[2] = '{3, 2'd0, 3'd4, 1'b1};
        vt[3] = '{1, 2'd1, 3'd2, 1'b0};
        vt[4] = '{1, 2'd0, 3'd5, 1'b0};
        vt[5] = '{1, 2'd0, 3'd7, 1'b0};
        vt[6] = '{0, 2'd3, 3'd0, 1'b0};
        vt[7] = '{3, 2'd0, 3'd3, 1'b1};

        rst         = 1'b1;
        sat_rst     = 1'b1;
        frag_ready  = 1'b0;
        lane_enable = '1;
        lane_dat    = '0;
        sat_lane    = '0;
        sat_lane[AW-1:0] = mk(2'd0, 3'd7);
        refresh();
        @(negedge clk);
        repeat (3) step();
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Single-fragment header cases, one lane at a time.
        frag_ready = 1'b1;
        exp_drops  = 0;
        for (int v = 0; v < 8; v++) begin
            d = mk(vt[v].dst, vt[v].fn);
            lq[vt[v].lane].push_back(d);
            refresh();
            if (vt[v].pass) sb.push_back('{d, 2'(vt[v].lane)});
            step();
            chk("t1_rd", AW'(rd_lane_fifo), AW'(1 << vt[v].lane));
            step();
            step();
            if (!vt[v].pass) exp_drops++;
            chk("t1_valid", AW'(frag_valid), AW'(vt[v].pass));
            chk("t1_drop", AW'(drop_cnt), AW'(exp_drops));
            step();
            chk("t1_idle", AW'(busy), '0);
        end

        // Fairness: all lanes loaded, ready tied high.
        glog.delete();
        for (int r = 0; r < 3; r++)
            for (int l = 0; l < NL; l++) begin
                d = mk(2'd0, 3'(r));
                lq[l].push_back(d);
                sb.push_back('{d, 2'(l)});
            end
        refresh();
        hs0 = hs_cnt;
        repeat (48) step();
        chk("t2_count", AW'(hs_cnt - hs0), AW'(12));
        chk("t2_reads", AW'(glog.size()), AW'(12));
        for (int k = 0; k < 12; k++) chk("t2_order", AW'(glog[k]), AW'(k % 4));
        chk("t2_sb", AW'(sb.size()), '0);

        // Drops still consume the lane's turn.
        glog.delete();
        drops0 = drop_cnt;
        lq[0].push_back(mk(2'd1, 3'd0));
        lq[1].push_back(mk(2'd0, 3'd7));
        d = mk(2'd0, 3'd3);
        lq[2].push_back(d);
        sb.push_back('{d, 2'd2});
        refresh();
        repeat (11) step();
        chk("t4_drop", AW'(drop_cnt), AW'(drops0 + 16'd2));
        chk("t4_n", AW'(glog.size()), AW'(3));
        for (int k = 0; k < 3; k++) chk("t4_order", AW'(glog[k]), AW'(k));
        chk("t4_sb", AW'(sb.size()), '0);

        // Backpressure in OFFER.
        glog.delete();
        frag_ready = 1'b0;
        d  = mk(2'd0, 3'd2);
        d2 = mk(2'd0, 3'd0);
        lq[1].push_back(d);
        lq[2].push_back(d2);
        sb.push_back('{d, 2'd1});
        sb.push_back('{d2, 2'd2});
        refresh();
        repeat (3) step();
        chk("t3_valid", AW'(frag_valid), AW'(1));
        hold   = frag_out;
        stable = 1;
        rdseen = 0;
        repeat (10) begin
            step();
            if (frag_valid !== 1'b1 || frag_out !== hold || frag_lane_id !== 2'd1) stable = 0;
            if (rd_lane_fifo !== '0) rdseen = 1;
        end
        chk("t3_stable", AW'(stable), AW'(1));
        chk("t3_no_rd", AW'(rdseen), '0);
        chk("t3_reads", AW'(glog.size()), AW'(1));
        frag_ready = 1'b1;
        step();
        chk("t3_accept", AW'(sb.size()), AW'(1));
        repeat (5) step();
        chk("t3_sb", AW'(sb.size()), '0);
        chk("t3_second", AW'(glog[1]), AW'(2));

        // Masking: only lanes 1 and 3 take turns; pointer sits at 2.
        glog.delete();
        lane_enable = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            a3[k] = mk(2'd0, 3'(k));
            a1[k] = mk(2'd0, 3'(k + 2));
            lq[3].push_back(a3[k]);
            lq[1].push_back(a1[k]);
            lq[0].push_back(mk(2'd0, 3'd0));
            lq[2].push_back(mk(2'd0, 3'd0));
        end
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{a3[k], 2'd3});
            sb.push_back('{a1[k], 2'd1});
        end
        refresh();
        repeat (17) step();
        chk("t5_n", AW'(glog.size()), AW'(4));
        for (int k = 0; k < 4; k++) chk("t5_order", AW'(glog[k]), (k % 2 == 0) ? AW'(3) : AW'(1));
        chk("t5_lane0", AW'(lq[0].size()), AW'(2));
        chk("t5_lane2", AW'(lq[2].size()), AW'(2));
        chk("t5_sb", AW'(sb.size()), '0);
        lq[0].delete();
        lq[2].delete();
        refresh();
        lane_enable = '1;

        // Reset while offering.
        frag_ready = 1'b0;
        lq[2].push_back(mk(2'd0, 3'd1));
        refresh();
        repeat (3) step();
        chk("t6_offer", AW'(frag_valid), AW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_outputs("t6");
        glog.delete();
        frag_ready = 1'b1;
        d  = mk(2'd0, 3'd0);
        d2 = mk(2'd0, 3'd4);
        lq[3].push_back(d);
        lq[0].push_back(d2);
        sb.push_back('{d2, 2'd0});
        sb.push_back('{d, 2'd3});
        refresh();
        repeat (9) step();
        chk("t6_first", AW'(glog[0]), AW'(0));
        chk("t6_second", AW'(glog[1]), AW'(3));
        chk("t6_sb", AW'(sb.size()), '0);

        // Saturation on a 3-bit counter: ten drops must stop at 7.
        sat_rst = 1'b0;
        repeat (30) step();
        chk("sat_value", AW'(sat_drop), AW'(7));
        chk("sat_wrap", AW'(sat_wrap), '0);
        chk("sat_lane", AW'(sat_bad), '0);
        chk("sat_busy", AW'(sat_busy_seen), AW'(1));
        chk("sat_valid", AW'(sat_valid), '0);
        chk("sat_out", sat_out, '0);
        chk("sat_id", AW'(sat_id), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
